// File: rtl/onchip_ram_loader_pkg.sv
// Shared types and constants for the on-chip RAM loader.
//   state_t  : loader FSM states
//   LANES    : byte lanes per RAM word
//   BYTE_W   : width of one stream byte / lane
//   SUM_W    : width of the byte checksum
//   lane_sum : checksum contribution of the enabled lanes of one word
package onchip_ram_loader_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned WORD_W = LANES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    VERIFY,
    DONE
  } state_t;

  // Sum of the bytes of w whose lane bit is set in mask (mod 2**SUM_W).
  function automatic logic [SUM_W-1:0] lane_sum(input logic [WORD_W-1:0] w,
                                                input logic [LANES-1:0]  mask);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (mask[i]) s = s + SUM_W'(w[i*BYTE_W +: BYTE_W]);
    end
    return s;
  endfunction

endpackage

// File: rtl/onchip_ram_loader_byte_packer.sv
// Packs stream bytes little-endian into one RAM word and keeps the write checksum.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_all    : clear word, lane mask and checksum (new load)
//   clr_word   : clear word and lane mask only (word has been written)
//   xfer       : a stream byte is transferred this cycle
//   lane       : lane the byte goes into
//   data       : stream byte
//   word       : packed word; lanes not yet filled read 0
//   mask       : lanes filled so far
//   wr_sum     : running sum of every byte accepted since clr_all
module onchip_ram_loader_byte_packer
  import onchip_ram_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_all,
  input  logic                     clr_word,
  input  logic                     xfer,
  input  logic [1:0]               lane,
  input  logic [BYTE_W-1:0]        data,
  output logic [WORD_W-1:0]        word,
  output logic [LANES-1:0]         mask,
  output logic [SUM_W-1:0]         wr_sum
);

  logic [LANES-1:0][BYTE_W-1:0] word_q;
  logic [LANES-1:0]             mask_q;
  logic [SUM_W-1:0]             sum_q;

  // Lane register, lane mask and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      mask_q <= '0;
      sum_q  <= '0;
    end else if (clr_all) begin
      word_q <= '0;
      mask_q <= '0;
      sum_q  <= '0;
    end else if (clr_word) begin
      word_q <= '0;
      mask_q <= '0;
    end else if (xfer) begin
      word_q[lane] <= data;
      mask_q[lane] <= 1'b1;
      sum_q        <= sum_q + SUM_W'(data);
    end
  end

  assign word   = word_q;
  assign mask   = mask_q;
  assign wr_sum = sum_q;

endmodule

// File: rtl/onchip_ram_loader.sv
// Avalon-MM loader for a single-port on-chip RAM: packs a byte stream into words,
// writes them with byteenable, then reads them back and compares a byte checksum.
//   clk, reset_n      : clock, asynchronous active-low reset
//   start             : load request pulse, taken only while busy=0
//   length_bytes      : bytes to load, sampled with start
//   in_data/valid/ready : byte stream handshake
//   busy, done, error, verify_ok : status; error/verify_ok held until next start
//   ram_*             : RAM master port (readdata arrives the cycle after a read)
module onchip_ram_loader
  import onchip_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_WORD = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W+2:0]   length_bytes,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                verify_ok,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [LANES-1:0]    ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [WORD_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [WORD_W-1:0]   ram_readdata
);

  localparam int unsigned LEN_W     = ADDR_W + 3;
  localparam int unsigned CAP_BYTES = LANES * (2 ** ADDR_W);

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    byte_cnt, byte_cnt_nxt;
  logic [LEN_W-1:0]    len, len_nxt;
  logic [ADDR_W-1:0]   word_addr, word_addr_nxt;
  logic [ADDR_W-1:0]   ram_address_nxt;
  logic                ram_chipselect_nxt, ram_write_nxt;
  logic                in_ready_nxt, busy_nxt, done_nxt, error_nxt, verify_ok_nxt;
  logic [SUM_W-1:0]    rd_sum, rd_sum_nxt;
  logic                rd_vld_d, rd_vld_d_nxt;
  logic [LANES-1:0]    rd_mask_d, rd_mask_d_nxt;

  logic                xfer_c, last_byte_c, too_long_c, clr_all_c, clr_word_c;
  logic [1:0]          lane_c;
  logic [ADDR_W-1:0]   last_addr_c;
  logic [LANES-1:0]    rd_mask_c;
  logic [SUM_W-1:0]    wr_sum;

  assign xfer_c      = in_valid & in_ready;
  assign lane_c      = byte_cnt[1:0];
  assign last_byte_c = (byte_cnt + LEN_W'(1)) == len;
  assign too_long_c  = ((LEN_W+1)'(BASE_WORD * LANES) + (LEN_W+1)'(length_bytes))
                       > (LEN_W+1)'(CAP_BYTES);
  assign last_addr_c = word_addr - ADDR_W'(1);

  // Lane mask of the read being presented: only the final word can be partial.
  always_comb begin
    rd_mask_c = '1;
    if (ram_address == last_addr_c) begin
      case (len[1:0])
        2'd1:    rd_mask_c = 4'b0001;
        2'd2:    rd_mask_c = 4'b0011;
        2'd3:    rd_mask_c = 4'b0111;
        default: rd_mask_c = 4'b1111;
      endcase
    end
  end

  onchip_ram_loader_byte_packer u_packer (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr_all  (clr_all_c),
    .clr_word (clr_word_c),
    .xfer     (xfer_c),
    .lane     (lane_c),
    .data     (in_data),
    .word     (ram_writedata),
    .mask     (ram_byteenable),
    .wr_sum   (wr_sum)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nxt          = state;
    byte_cnt_nxt       = byte_cnt;
    len_nxt            = len;
    word_addr_nxt      = word_addr;
    ram_address_nxt    = ram_address;
    ram_chipselect_nxt = 1'b0;
    ram_write_nxt      = 1'b0;
    done_nxt           = 1'b0;
    error_nxt          = error;
    verify_ok_nxt      = verify_ok;
    clr_all_c          = 1'b0;
    clr_word_c         = 1'b0;
    in_ready_nxt       = 1'b0;
    busy_nxt           = 1'b0;

    // Readback pipeline: data for a read lands one cycle after it was presented.
    rd_vld_d_nxt  = ram_chipselect & ~ram_write;
    rd_mask_d_nxt = rd_mask_c;
    rd_sum_nxt    = rd_sum;
    if (rd_vld_d) rd_sum_nxt = rd_sum + lane_sum(ram_readdata, rd_mask_d);

    case (state)
      IDLE: begin
        if (start) begin
          clr_all_c     = 1'b1;
          byte_cnt_nxt  = '0;
          len_nxt       = length_bytes;
          word_addr_nxt = ADDR_W'(BASE_WORD);
          rd_sum_nxt    = '0;
          if (length_bytes == '0) begin
            state_nxt     = DONE;
            done_nxt      = 1'b1;
            error_nxt     = 1'b0;
            verify_ok_nxt = 1'b1;
          end else if (too_long_c) begin
            state_nxt     = DONE;
            done_nxt      = 1'b1;
            error_nxt     = 1'b1;
            verify_ok_nxt = 1'b0;
          end else begin
            state_nxt     = FILL;
            error_nxt     = 1'b0;
            verify_ok_nxt = 1'b0;
          end
        end
      end

      FILL: begin
        if (xfer_c) begin
          byte_cnt_nxt = byte_cnt + LEN_W'(1);
          if (lane_c == 2'd3 || last_byte_c) begin
            state_nxt          = WRITE;
            ram_chipselect_nxt = 1'b1;
            ram_write_nxt      = 1'b1;
            ram_address_nxt    = word_addr;
          end
        end
      end

      WRITE: begin
        clr_word_c    = 1'b1;
        word_addr_nxt = word_addr + ADDR_W'(1);
        if (byte_cnt == len) begin
          state_nxt          = VERIFY;
          ram_chipselect_nxt = 1'b1;
          ram_address_nxt    = ADDR_W'(BASE_WORD);
        end else begin
          state_nxt = FILL;
        end
      end

      VERIFY: begin
        if (ram_chipselect) begin
          // Keep reading until the last written word, then idle one cycle for its data.
          if (ram_address != last_addr_c) begin
            ram_chipselect_nxt = 1'b1;
            ram_address_nxt    = ram_address + ADDR_W'(1);
          end
        end else begin
          state_nxt     = DONE;
          done_nxt      = 1'b1;
          error_nxt     = 1'b0;
          verify_ok_nxt = (rd_sum_nxt == wr_sum);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    in_ready_nxt = (state_nxt == FILL);
    busy_nxt     = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      len            <= '0;
      word_addr      <= '0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      in_ready       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      verify_ok      <= 1'b0;
      rd_sum         <= '0;
      rd_vld_d       <= 1'b0;
      rd_mask_d      <= '0;
    end else begin
      state          <= state_nxt;
      byte_cnt       <= byte_cnt_nxt;
      len            <= len_nxt;
      word_addr      <= word_addr_nxt;
      ram_address    <= ram_address_nxt;
      ram_chipselect <= ram_chipselect_nxt;
      ram_write      <= ram_write_nxt;
      in_ready       <= in_ready_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      error          <= error_nxt;
      verify_ok      <= verify_ok_nxt;
      rd_sum         <= rd_sum_nxt;
      rd_vld_d       <= rd_vld_d_nxt;
      rd_mask_d      <= rd_mask_d_nxt;
    end
  end

  assign ram_clken = 1'b1;

endmodule
